// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared widths and state encoding for word_serializer and its downstream shifter
package ser_pkg;

    localparam int WIDTH  = 16;
    localparam int CNT_W  = 4;
    localparam int WCNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/word_skid_buf.sv
// rtl/word_skid_buf.sv - one-entry holding buffer, compiled only when SER_SKID_EN is defined
`ifdef SER_SKID_EN
module word_skid_buf
    import ser_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic [W-1:0] data,
    output logic         ready
);

    // Data register and full flag; a push in the same cycle as a pop keeps the entry full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (push) begin
                data <= push_data;
            end
            if (push) begin
                full <= 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

    // Space is available only while the entry is empty and the block is out of reset.
    assign ready = !full && reset;

endmodule
`endif

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - MSB-first parallel-to-serial transmitter; SER_SKID_EN adds a one-word skid buffer
module word_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH  = ser_pkg::WIDTH,
    parameter int CNT_W  = ser_pkg::CNT_W,
    parameter int WCNT_W = ser_pkg::WCNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  din_word,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ser_d,
    output logic              ser_en,
    output logic              busy,
    output logic              word_done,
    output logic [WCNT_W-1:0] words_sent
);

    ser_state_t        state, state_next;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  bitcnt;
    logic [WCNT_W-1:0] wcnt;
    logic              last;
    logic              xfer;
    logic              load;
    logic [WIDTH-1:0]  load_word;
    logic              buf_full;

    assign last = (state == SHIFT) && (bitcnt == CNT_W'(WIDTH - 1));
    assign xfer = din_valid && din_ready;

`ifdef SER_SKID_EN
    logic             buf_push;
    logic             buf_pop;
    logic [WIDTH-1:0] buf_data;

    word_skid_buf #(.W(WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .pop       (buf_pop),
        .push_data (din_word),
        .full      (buf_full),
        .data      (buf_data),
        .ready     (din_ready)
    );

    // Route each accepted word to shreg or the buffer and pick the next state.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_word  = din_word;
        buf_push   = 1'b0;
        buf_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    if (buf_full) begin
                        load      = 1'b1;
                        load_word = buf_data;
                        buf_pop   = 1'b1;
                        buf_push  = xfer;
                    end else if (xfer) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    buf_push = xfer;
                end
            end
            default: state_next = IDLE;
        endcase
    end
`else
    assign buf_full  = 1'b0;
    assign din_ready = (state == IDLE) && reset;

    // Accept only when idle; always return to idle after the last bit.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_word  = din_word;
        case (state)
            IDLE: begin
                if (xfer) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift register, bit counter and completed-word counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg  <= '0;
            bitcnt <= '0;
            wcnt   <= '0;
        end else begin
            if (load) begin
                shreg  <= load_word;
                bitcnt <= '0;
            end else if (state == SHIFT) begin
                shreg  <= {shreg[WIDTH-2:0], 1'b0};
                bitcnt <= bitcnt + 1'b1;
            end
            if (last) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    // Serial outputs come from registers only, so inputs cannot glitch them.
    always_comb begin
        ser_en    = (state == SHIFT);
        ser_d     = shreg[WIDTH-1];
        word_done = last;
        busy      = (state == SHIFT) || buf_full;
    end

    assign words_sent = wcnt;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - randomized self-checking bench for word_serializer (honours SER_SKID_EN)
module tb_word_serializer;

`ifdef SER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din_word = 16'h0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        ser_d;
    logic        ser_en;
    logic        busy;
    logic        word_done;
    logic [7:0]  words_sent;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    word_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .din_word   (din_word),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ser_d      (ser_d),
        .ser_en     (ser_en),
        .busy       (busy),
        .word_done  (word_done),
        .words_sent (words_sent)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of bits still to leave for the current frame
    // plus a queue of accepted words waiting for it.
    bit          m_cur[$];
    logic [15:0] m_pend[$];
    logic [15:0] m_sb[$];
    int          m_words = 0;
    bit          m_fire = 1'b0;
    logic [15:0] rx = 16'h0;
    int          rx_cnt = 0;
    logic [15:0] last_rx = 16'h0;
    int          n_fire = 0;
    int          n_done = 0;
    bit          saw_wrap = 1'b0;
    logic [7:0]  prev_ws = 8'h0;

    function automatic bit exp_ready();
        if (!reset) return 1'b0;
        if (SKID) return m_pend.size() == 0;
        return m_cur.size() == 0;
    endfunction

    always @(posedge clk) begin
        logic [15:0] w;
        if (!reset) begin
            m_cur.delete();
            m_pend.delete();
            m_sb.delete();
            m_words = 0;
            m_fire  = 1'b0;
            rx_cnt  = 0;
        end else begin
            m_fire = din_valid && exp_ready();
            if (m_cur.size() > 0) begin
                void'(m_cur.pop_front());
                if (m_cur.size() == 0) m_words = (m_words + 1) % 256;
            end
            if (m_fire) begin
                m_pend.push_back(din_word);
                m_sb.push_back(din_word);
                n_fire++;
            end
            if (m_cur.size() == 0 && m_pend.size() > 0) begin
                w = m_pend.pop_front();
                for (int i = 15; i >= 0; i--) m_cur.push_back(w[i]);
            end
        end
    end

    task automatic do_cycle();
        logic [15:0] exp_w;
        @(posedge clk);
        #1;
        chk("ser_en", ser_en, m_cur.size() > 0);
        if (m_cur.size() > 0) chk("ser_d", ser_d, m_cur[0]);
        else chk("ser_d_idle", ser_d, 0);
        chk("word_done", word_done, m_cur.size() == 1);
        chk("busy", busy, (m_cur.size() > 0) || (m_pend.size() > 0));
        chk("din_ready", din_ready, exp_ready());
        chk("words_sent", words_sent, m_words);
        if (word_done === 1'b1) n_done++;
        if (prev_ws == 8'hFF && words_sent == 8'h00) saw_wrap = 1'b1;
        prev_ws = words_sent;
        // Downstream shifter: collect enabled bits, compare each completed frame.
        if (reset && ser_en === 1'b1) begin
            rx = {rx[14:0], ser_d};
            rx_cnt++;
            if (rx_cnt == 16) begin
                rx_cnt  = 0;
                last_rx = rx;
                if (m_sb.size() > 0) begin
                    exp_w = m_sb.pop_front();
                    chk("rx_word", rx, exp_w);
                end else begin
                    chk("rx_extra", 1, 0);
                end
            end
        end
    endtask

    logic [15:0] src_q[$];

    task automatic run(input int max_cycles, input bit rand_gaps);
        int c = 0;
        while ((src_q.size() > 0 || din_valid) && c < max_cycles) begin
            if (!din_valid && src_q.size() > 0 && (!rand_gaps || $urandom_range(3) != 0)) begin
                din_word  = src_q.pop_front();
                din_valid = 1'b1;
            end
            do_cycle();
            c++;
            if (m_fire) begin
                din_valid = 1'b0;
                din_word  = 16'($urandom);
            end
        end
        chk("drain_timeout", c < max_cycles, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        int w0;
        // Reset
        reset = 1'b0;
        idle(3);
        chk("rst_words", words_sent, 0);
        chk("rst_ser_en", ser_en, 0);
        reset = 1'b1;
        idle(2);

        // Single word
        src_q.push_back(16'hA5C3);
        run(40, 1'b0);
        idle(20);
        chk("a5c3_rx", last_rx, 16'hA5C3);
        chk("a5c3_count", words_sent, 1);

        // Two words held valid back to back
        src_q.push_back(16'h0001);
        src_q.push_back(16'hFFFF);
        run(80, 1'b0);
        idle(20);
        chk("pair_rx_last", last_rx, 16'hFFFF);

        // Random words with random source gaps
        n_fire = 0;
        n_done = 0;
        for (int i = 0; i < 40; i++) src_q.push_back(16'($urandom));
        run(2000, 1'b1);
        idle(20);
        chk("done_vs_fire", n_done, n_fire);

        // Reset during bit 7 of 16'h1234
        src_q.push_back(16'h1234);
        run(40, 1'b0);
        idle(7);
        reset = 1'b0;
        do_cycle();
        chk("midrst_ser_en", ser_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_words", words_sent, 0);
        reset = 1'b1;
        src_q.push_back(16'hBEEF);
        run(40, 1'b0);
        idle(20);
        chk("beef_rx", last_rx, 16'hBEEF);

        // 256 back-to-back words: counter wraps
        w0 = words_sent;
        saw_wrap = 1'b0;
        n_fire = 0;
        n_done = 0;
        for (int i = 0; i < 256; i++) src_q.push_back(16'($urandom));
        run(256 * 18 + 50, 1'b0);
        idle(40);
        chk("wrap_seen", saw_wrap, 1);
        chk("wrap_count", words_sent, w0);
        chk("wrap_done_vs_fire", n_done, 256);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
